// File: rtl/fe_ctrl_pkg.sv
// Shared encodings and defaults for the fetch/decode pipeline controller.
package fe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_WARM  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } fe_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_FLUSH   = 2'd1,
    CAUSE_MISPRED = 2'd2,
    CAUSE_TRAP    = 2'd3
  } fe_cause_e;

  localparam int DEF_WARMUP_CYCLES = 10;
  localparam int DEF_FLUSH_DRAIN   = 2;
  localparam int DEF_CNT_W         = 4;

endpackage

// File: rtl/fe_ctrl_cnt.sv
// Loadable up/down counter shared by warm-up (counts up) and drain (counts down).
module fe_ctrl_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt
);

  // load beats inc beats dec; only one is ever requested per state
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (load) cnt <= load_val;
    else if (inc)  cnt <= cnt + 1'b1;
    else if (dec)  cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/fe_pipe_ctrl.sv
// Fetch/decode pipeline controller: merges stall/flush sources into the
// fetch-to-decode register controls, sequences flush recovery and gates the BTB.
module fe_pipe_ctrl
  import fe_ctrl_pkg::*;
#(
  parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
  parameter int FLUSH_DRAIN   = DEF_FLUSH_DRAIN,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       cpurst,
  input  logic       de_stall,
  input  logic       de_store_load_conflict,
  input  logic       exe_store_load_conflict,
  input  logic       readram_stall,
  input  logic       mem_stall,
  input  logic       mult_stall,
  input  logic       fet_flush,
  input  logic       branch_predict_err,
  input  logic       mem2wb_exp_ffout,
  input  logic       interrupt,
  input  logic       cross_bd_ff,
  input  logic       de2fe_branch,
  input  logic       de2ex_inst_valid,
  output logic       fet_stall,
  output logic       fe2de_ctl_en,
  output logic       fe2de_data_en,
  output logic       fe2de_bubble,
  output logic       pc_redirect,
  output logic [1:0] redirect_cause,
  output logic       trap_pending,
  output logic       btb_valid,
  output logic       btb_wr,
  output logic [1:0] ctrl_state
);

  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LD  = CNT_W'(FLUSH_DRAIN);

  fe_state_e        state;
  fe_cause_e        evt_cause;
  logic [CNT_W-1:0] cnt;
  logic             in_run, in_rcv, trap, flush_evt, retrap, enter_flush, btb_armed;

  assign fet_stall = de_stall | de_store_load_conflict | exe_store_load_conflict |
                     readram_stall | mem_stall | mult_stall;

  // a pending interrupt waits for an unstalled cycle; a writeback exception does not
  assign trap        = mem2wb_exp_ffout | (trap_pending & ~fet_stall);
  assign in_run      = (state == ST_RUN);
  assign in_rcv      = (state == ST_FLUSH) | (state == ST_DRAIN);
  assign flush_evt   = in_run & (trap | branch_predict_err | fet_flush);
  // during recovery only a trap matters; mispredict/flush refer to squashed work
  assign retrap      = in_rcv & trap;
  assign enter_flush = flush_evt | retrap;
  assign evt_cause   = trap ? CAUSE_TRAP : (branch_predict_err ? CAUSE_MISPRED : CAUSE_FLUSH);

  assign fe2de_ctl_en  = in_run & ~de_stall & ~de_store_load_conflict;
  assign fe2de_data_en = fe2de_ctl_en & ~fet_stall;
  assign fe2de_bubble  = in_run ? (flush_evt | (cross_bd_ff & ~de_stall)) : 1'b1;
  assign btb_wr        = btb_armed & de2ex_inst_valid & btb_valid;
  assign ctrl_state    = state;

  fe_ctrl_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (cpurst),
    .load     (state == ST_FLUSH),
    .load_val (DRAIN_LD),
    .inc      (state == ST_WARM),
    .dec      (state == ST_DRAIN),
    .cnt      (cnt)
  );

  // main sequencer; redirect pulse and cause are registered on entry to FLUSH
  always_ff @(posedge clk or posedge cpurst) begin
    if (cpurst) begin
      state          <= ST_WARM;
      btb_valid      <= 1'b0;
      pc_redirect    <= 1'b0;
      redirect_cause <= CAUSE_NONE;
    end else begin
      pc_redirect    <= 1'b0;
      redirect_cause <= CAUSE_NONE;
      case (state)
        ST_WARM: if (cnt == WARM_LAST) begin
          state     <= ST_RUN;
          btb_valid <= 1'b1;
        end
        ST_RUN: if (flush_evt) begin
          state          <= ST_FLUSH;
          pc_redirect    <= 1'b1;
          redirect_cause <= evt_cause;
        end
        ST_FLUSH: if (trap) begin
          pc_redirect    <= 1'b1;
          redirect_cause <= CAUSE_TRAP;
        end else begin
          state <= (FLUSH_DRAIN == 0) ? ST_RUN : ST_DRAIN;
        end
        ST_DRAIN: if (trap) begin
          state          <= ST_FLUSH;
          pc_redirect    <= 1'b1;
          redirect_cause <= CAUSE_TRAP;
        end else if (cnt == CNT_W'(1)) begin
          state <= ST_RUN;
        end
        default: state <= ST_WARM;
      endcase
    end
  end

  // interrupt latch; a new request in the taking cycle keeps it pending
  always_ff @(posedge clk or posedge cpurst) begin
    if (cpurst)                              trap_pending <= 1'b0;
    else if (interrupt)                      trap_pending <= 1'b1;
    else if (trap && (state != ST_WARM))     trap_pending <= 1'b0;
  end

  // BTB capture arm: set by a resolved branch, dropped after one capture or a flush
  always_ff @(posedge clk or posedge cpurst) begin
    if (cpurst)                         btb_armed <= 1'b0;
    else if (enter_flush || btb_wr)     btb_armed <= 1'b0;
    else if (de2fe_branch && in_run)    btb_armed <= 1'b1;
  end

endmodule

// File: tb/tb_fe_pipe_ctrl.sv
// Randomized bench for fe_pipe_ctrl against a cycle-level behavioural model.
module tb_fe_pipe_ctrl;

  localparam int W = 10;
  localparam int D = 2;

  logic       clk = 1'b0;
  logic       cpurst;
  logic       de_stall, de_store_load_conflict, exe_store_load_conflict;
  logic       readram_stall, mem_stall, mult_stall;
  logic       fet_flush, branch_predict_err, mem2wb_exp_ffout, interrupt;
  logic       cross_bd_ff, de2fe_branch, de2ex_inst_valid;
  logic       fet_stall, fe2de_ctl_en, fe2de_data_en, fe2de_bubble, pc_redirect;
  logic [1:0] redirect_cause, ctrl_state;
  logic       trap_pending, btb_valid, btb_wr;

  fe_pipe_ctrl #(.WARMUP_CYCLES(W), .FLUSH_DRAIN(D), .CNT_W(4)) dut (
    .clk(clk), .cpurst(cpurst),
    .de_stall(de_stall), .de_store_load_conflict(de_store_load_conflict),
    .exe_store_load_conflict(exe_store_load_conflict), .readram_stall(readram_stall),
    .mem_stall(mem_stall), .mult_stall(mult_stall),
    .fet_flush(fet_flush), .branch_predict_err(branch_predict_err),
    .mem2wb_exp_ffout(mem2wb_exp_ffout), .interrupt(interrupt),
    .cross_bd_ff(cross_bd_ff), .de2fe_branch(de2fe_branch),
    .de2ex_inst_valid(de2ex_inst_valid),
    .fet_stall(fet_stall), .fe2de_ctl_en(fe2de_ctl_en), .fe2de_data_en(fe2de_data_en),
    .fe2de_bubble(fe2de_bubble), .pc_redirect(pc_redirect),
    .redirect_cause(redirect_cause), .trap_pending(trap_pending),
    .btb_valid(btb_valid), .btb_wr(btb_wr), .ctrl_state(ctrl_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h want %0h", tag, $time, act, exp);
    end
  endtask

  // model: elapsed warm-up cycles, one-cycle flush flag, remaining drain cycles
  int m_age, m_drain, m_cause;
  bit m_flush, m_pend, m_armed, m_btbv;

  task automatic model_reset();
    m_age = 0; m_drain = 0; m_cause = 0;
    m_flush = 0; m_pend = 0; m_armed = 0; m_btbv = 0;
  endtask

  function automatic bit any_stall();
    return de_stall | de_store_load_conflict | exe_store_load_conflict |
           readram_stall | mem_stall | mult_stall;
  endfunction

  function automatic bit m_trap();
    return mem2wb_exp_ffout | (m_pend & ~any_stall());
  endfunction

  function automatic bit m_run();
    return m_btbv && !m_flush && (m_drain == 0);
  endfunction

  task automatic check_outputs();
    bit st, run, evt, ctl;
    int exp_state;
    st  = any_stall();
    run = m_run();
    evt = m_trap() | branch_predict_err | fet_flush;
    ctl = run & ~de_stall & ~de_store_load_conflict;
    exp_state = !m_btbv ? 0 : m_flush ? 2 : (m_drain > 0) ? 3 : 1;
    chk("fet_stall", fet_stall, st);
    chk("ctl_en", fe2de_ctl_en, ctl);
    chk("data_en", fe2de_data_en, ctl & ~st);
    chk("bubble", fe2de_bubble, run ? (evt | (cross_bd_ff & ~de_stall)) : 1'b1);
    chk("pc_redirect", pc_redirect, m_flush);
    chk("cause", redirect_cause, m_flush ? m_cause : 0);
    chk("trap_pending", trap_pending, m_pend);
    chk("btb_valid", btb_valid, m_btbv);
    chk("btb_wr", btb_wr, m_armed & de2ex_inst_valid & m_btbv);
    chk("ctrl_state", ctrl_state, exp_state);
  endtask

  task automatic model_step();
    bit warm, run, rcv, trap, wr, enter;
    int ncause;
    warm  = !m_btbv;
    run   = m_run();
    rcv   = m_flush || (m_drain > 0);
    trap  = m_trap();
    wr    = m_armed & de2ex_inst_valid & m_btbv;
    enter = (run && (trap || branch_predict_err || fet_flush)) || (rcv && trap);
    ncause = trap ? 3 : branch_predict_err ? 2 : 1;
    if (interrupt)          m_pend = 1;
    else if (trap && !warm) m_pend = 0;
    if (enter || wr)                m_armed = 0;
    else if (de2fe_branch && run)   m_armed = 1;
    if (warm) begin
      m_age++;
      if (m_age == W) m_btbv = 1;
    end else if (enter) begin
      m_flush = 1; m_drain = 0; m_cause = ncause;
    end else if (m_flush) begin
      m_flush = 0; m_drain = D;
    end else if (m_drain > 0) begin
      m_drain--;
    end
  endtask

  task automatic zero_inputs();
    de_stall = 0; de_store_load_conflict = 0; exe_store_load_conflict = 0;
    readram_stall = 0; mem_stall = 0; mult_stall = 0;
    fet_flush = 0; branch_predict_err = 0; mem2wb_exp_ffout = 0; interrupt = 0;
    cross_bd_ff = 0; de2fe_branch = 0; de2ex_inst_valid = 0;
  endtask

  task automatic rand_inputs();
    de_stall                = ($urandom_range(0, 15) == 0);
    de_store_load_conflict  = ($urandom_range(0, 15) == 0);
    exe_store_load_conflict = ($urandom_range(0, 15) == 0);
    readram_stall           = ($urandom_range(0, 15) == 0);
    mem_stall               = ($urandom_range(0, 15) == 0);
    mult_stall              = ($urandom_range(0, 7) == 0);
    fet_flush               = ($urandom_range(0, 19) == 0);
    branch_predict_err      = ($urandom_range(0, 19) == 0);
    mem2wb_exp_ffout        = ($urandom_range(0, 59) == 0);
    interrupt               = ($urandom_range(0, 29) == 0);
    cross_bd_ff             = ($urandom_range(0, 5) == 0);
    de2fe_branch            = ($urandom_range(0, 7) == 0);
    de2ex_inst_valid        = ($urandom_range(0, 1) == 0);
  endtask

  initial begin
    cpurst = 1'b1;
    zero_inputs();
    model_reset();
    @(negedge clk);
    #1 check_outputs();
    cpurst = 1'b0;
    @(posedge clk);
    model_step();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (cyc < 20) zero_inputs();
      else          rand_inputs();
      #1 check_outputs();
      // asynchronous reset mid-cycle, biased toward landing in drain
      if (cyc > 100 && ((m_drain > 0) ? ($urandom_range(0, 19) == 0)
                                      : ($urandom_range(0, 499) == 0))) begin
        #1 cpurst = 1'b1;
        #1 model_reset();
        check_outputs();
        #1 cpurst = 1'b0;
      end
      @(posedge clk);
      model_step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fe_pipe_ctrl.md
# fe_pipe_ctrl

Fetch/decode pipeline controller. It merges all stall and flush sources into the load, hold and bubble controls for the fetch-to-decode pipeline register and sequences recovery after flushes, mispredicts and traps. It also gates BTB warm-up and BTB capture. The block sits between the hazard and exception logic and the fetch stage.

## Interface
Parameters:
- WARMUP_CYCLES, 10: post-reset cycles before BTB hits are allowed and the pipe runs.
- FLUSH_DRAIN, 2: bubble cycles after the FLUSH cycle.
- CNT_W, 4: shared counter width; must hold max(WARMUP_CYCLES, FLUSH_DRAIN).

Ports (clock and reset first):
- clk  in  1  sole clock, posedge.
- cpurst  in  1  reset, asynchronous, active-high.
- de_stall, de_store_load_conflict, exe_store_load_conflict, readram_stall, mem_stall, mult_stall  in  1 each  stall sources.
- fet_flush  in  1  fetch flush request.
- branch_predict_err  in  1  mispredict.
- mem2wb_exp_ffout  in  1  exception from writeback.
- interrupt  in  1  level interrupt request.
- cross_bd_ff  in  1  instruction straddles a fetch boundary; insert a bubble.
- de2fe_branch  in  1  decode resolved a branch.
- de2ex_inst_valid  in  1  valid instruction leaving decode.
- fet_stall  out  1  OR of all six stall sources.
- fe2de_ctl_en  out  1  load enable for the decode flag registers.
- fe2de_data_en  out  1  load enable for the decode pc and instruction registers.
- fe2de_bubble  out  1  load zeros (NOP) into the decode instruction and flag registers.
- pc_redirect  out  1  one-cycle redirect pulse.
- redirect_cause  out  2  0 none, 1 fet_flush, 2 mispredict, 3 trap.
- trap_pending  out  1  interrupt latched but not yet taken.
- btb_valid  out  1  BTB hits permitted.
- btb_wr  out  1  capture the decode pc and instruction into the BTB.
- ctrl_state  out  2  current FSM state.

## Operation
- States: WARM=0, RUN=1, FLUSH=2, DRAIN=3.
- Reset values: state WARM, counter 0, trap_pending 0, btb_valid 0, btb armed 0, cause 0. All registered outputs are 0.
- **WARM**
  - The counter increments every cycle.
  - When the counter reaches WARMUP_CYCLES-1, the FSM goes to RUN and btb_valid sets (it stays set until reset).
  - fe2de_bubble is 1 throughout; both enables are 0.
- **Flush event**, evaluated only in RUN. Priority: trap > branch_predict_err > fet_flush.
  - trap = mem2wb_exp_ffout | (trap_pending & ~fet_stall).
  - mem2wb_exp_ffout is taken even while stalled.
- **Interrupts**
  - interrupt sets trap_pending in any state.
  - trap_pending clears on the edge at which the trap is taken.
  - Set and clear in the same cycle: clear wins only if interrupt is low.
- **RUN**
  - fe2de_ctl_en = ~de_stall & ~de_store_load_conflict.
  - fe2de_data_en = fe2de_ctl_en & ~fet_stall.
  - fe2de_bubble = flush_evt | (cross_bd_ff & ~de_stall).
  - On flush_evt, latch the cause and go to FLUSH.
- **FLUSH** (1 cycle)
  - pc_redirect=1, redirect_cause=latched cause, bubble=1, enables 0.
  - Load counter with FLUSH_DRAIN, then go to DRAIN (or RUN if FLUSH_DRAIN=0).
- **DRAIN**
  - bubble=1; the counter decrements; go to RUN when the counter reaches 1.
  - A trap in FLUSH/DRAIN re-enters FLUSH with cause 3.
  - Mispredict and fet_flush in FLUSH/DRAIN are ignored (stale).
- redirect_cause is 0 outside FLUSH.
- **BTB**
  - armed sets on de2fe_branch in RUN.
  - btb_wr = armed & de2ex_inst_valid & btb_valid.
  - armed clears on the edge after btb_wr; clear wins over a simultaneous set.
  - Entering FLUSH also clears armed.
- Reset mid-operation returns to WARM immediately and restarts warm-up in full.

## Timing
- fet_stall, the enables, fe2de_bubble and btb_wr are combinational from inputs and current state (zero latency).
- pc_redirect asserts exactly one cycle after the flush event edge.
- From flush event to the first fe2de_data_en=1: FLUSH_DRAIN+2 cycles, absent stalls.
- btb_valid rises on edge WARMUP_CYCLES after reset release.
- All state updates occur on posedge clk; cpurst acts asynchronously.

## Structure
- Package fe_ctrl_pkg holds:
  - state encoding (WARM/RUN/FLUSH/DRAIN);
  - cause encoding (NONE/FLUSH/MISPRED/TRAP);
  - default WARMUP_CYCLES and FLUSH_DRAIN.
- Sub-module fe_ctrl_cnt: a loadable up/down counter of CNT_W bits with async reset, shared by warm-up and drain.

## Test plan
- Reset release, no events: ctrl_state is WARM for 10 cycles, bubble=1, btb_valid=0. On cycle 10, RUN and btb_valid=1.
- RUN, branch_predict_err and fet_flush pulsed together: bubble=1 same cycle. Next cycle pc_redirect=1 with cause=2, then 2 DRAIN cycles, then fe2de_data_en=1.
- interrupt pulsed while mult_stall=1 for 3 cycles: trap_pending=1 and no redirect while stalled. The trap is taken on the first unstalled cycle, then cause=3 and trap_pending=0.
- Mispredict followed by mem2wb_exp_ffout during DRAIN: FLUSH re-entered with cause=3. A mispredict arriving during DRAIN produces no redirect.
- de2fe_branch in RUN, de2ex_inst_valid two cycles later: btb_wr=1 for exactly one cycle. With de2fe_branch during WARM, btb_wr stays 0.
- cpurst asserted mid-DRAIN: state returns to WARM asynchronously, all outputs reset, and the full 10-cycle warm-up repeats.
